// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the producer holds data stable while valid is high and ready is low.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH, one bit per clock, LSB first.
// Results land in a separate output register so diff/bout only change when an operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus,
    output logic [1:0]          o_dbg_state
);
    localparam int CW = $clog2(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serial_subtractor: WIDTH must be in 2..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_ai;
    logic             w_bi;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    assign w_accept   = (r_state == S_IDLE) && bus.in_valid;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_ai       = r_a[0];
    assign w_bi       = r_b[0];
    assign w_d        = w_ai ^ w_bi ^ r_br;
    assign w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    // Difference bits enter at the MSB so bit 0 reaches position 0 after WIDTH shifts.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_state_next = S_RUN;
            S_RUN:   if (w_last)        w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_br  <= bus.bin;
                        r_cnt <= '0;
                        r_res <= '0;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next;
                    // Counter parks on WIDTH-1; its value is meaningless outside RUN.
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bout <= w_br_next;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_RUN);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign o_dbg_state   = r_state;

    a_one_phase: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot({bus.in_ready, bus.busy, bus.out_valid}));

    a_hold_done: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.diff) && $stable(bus.bout)));
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and table-driven bench for serial_subtractor at WIDTH = 8.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [W:0] exp_q[$];   // {bout, diff}

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // waits for out_valid, checks hold behaviour, result, and return to IDLE
  task automatic finish_op(input int hold, input bit chk_lat);
    int lat;
    logic [W:0] e;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.out_valid !== 1'b1) begin
      check("result_timeout", {31'd0, bus.out_valid}, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      bus.out_ready = 1'b1;
      return;
    end
    if (chk_lat) check("latency", lat, W);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("hold_result", {23'd0, bus.bout, bus.diff}, {23'd0, e});
      @(posedge clk); #1;
    end
    check("diff", {24'd0, bus.diff}, {24'd0, e[W-1:0]});
    check("bout", {31'd0, bus.bout}, {31'd0, e[W]});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("back_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("back_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  // driver: presents one operand set, confirms acceptance, then completes it
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input int hold, input bit chk_lat);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    exp_q.push_back({eb, ed});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("accept_busy", {31'd0, bus.busy}, 32'd1);
    finish_op(hold, chk_lat);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    logic rbin;
    logic [W:0] rm;
    logic [W:0] e;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1};
    vecs[8] = '{8'h12, 8'h12, 1'b1, 8'hFF, 1'b1};
    vecs[9] = '{8'h12, 8'h11, 1'b1, 8'h00, 1'b0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_diff", {24'd0, bus.diff}, 32'd0);
    check("rst_bout", {31'd0, bus.bout}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // first accept on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b1;
    bus.a = 8'h05;
    bus.b = 8'h03;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h02});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("first_accept_busy", {31'd0, bus.busy}, 32'd1);
    finish_op(0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, 0, 1'b1);
    end

    // backpressure: result held five cycles
    run_op(8'hA0, 8'h0F, 1'b0, 8'h91, 1'b0, 5, 1'b1);

    // operands offered during RUN and DONE are ignored
    @(negedge clk);
    bus.a = 8'h30;
    bus.b = 8'h10;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check("ign_accept_busy", {31'd0, bus.busy}, 32'd1);
    bus.a = 8'hFF;
    bus.b = 8'h00;
    bus.bin = 1'b1;
    seen = 0;
    while (bus.out_valid !== 1'b1 && seen < 40) begin
      @(posedge clk); #1;
      seen++;
    end
    check("ign_latency", seen, W);
    repeat (2) begin
      @(posedge clk); #1;
      check("ign_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("ign_result", {23'd0, bus.bout, bus.diff}, {23'd0, 1'b0, 8'h20});
    end
    // out_ready and in_valid together in DONE: leave to IDLE, no accept yet
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("done_no_accept_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("done_no_accept_busy", {31'd0, bus.busy}, 32'd0);
    exp_q.push_back({1'b0, 8'hFE});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("accept_after_idle", {31'd0, bus.busy}, 32'd1);
    finish_op(0, 1'b1);

    // reset during the third RUN cycle
    @(negedge clk);
    bus.a = 8'h77;
    bus.b = 8'h11;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_diff", {24'd0, bus.diff}, 32'd0);
    check("abort_bout", {31'd0, bus.bout}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("abort_no_spurious", seen, 0);
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0, 1'b1);

    // random back-to-back against a wide-subtraction reference
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      rm = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      run_op(ra, rb, rbin, rm[W-1:0], rm[W], $urandom_range(0, 2), 1'b1);
    end

    check("exp_q_drained", exp_q.size(), 0);
    e = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
